// File: rtl/execute_stage.sv
// execute_stage: operand forwarding, NZCV condition check, single-cycle ALU and a sequenced MUL.
// Latency: ADD..SHR are combinational (0 cycles); MUL holds Execute for MUL_LAT cycles, result in the last one.
// Backpressure: BusyE stays high while a MUL is in flight so the hazard unit stalls F/D and clears D/E.
module execute_stage #(
    parameter int N       = 24,
    parameter int MUL_LAT = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         PCSrcE,
    input  logic         RegWriteE,
    input  logic         MemtoRegE,
    input  logic         MemWriteE,
    input  logic [2:0]   ALUControlE,
    input  logic         BranchE,
    input  logic         ALUSrcE,
    input  logic [1:0]   FlagWriteE,
    input  logic         CondE,
    input  logic [3:0]   FlagsE,
    input  logic [N-1:0] RD1E,
    input  logic [N-1:0] RD2E,
    input  logic [N-1:0] ExtImmE,
    input  logic [3:0]   A3E,
    input  logic [1:0]   ForwardAE,
    input  logic [1:0]   ForwardBE,
    input  logic [N-1:0] ALUResultM,
    input  logic [N-1:0] ResultW,
    output logic [N-1:0] ALUResultE,
    output logic [N-1:0] WriteDataE,
    output logic [3:0]   WA3E,
    output logic         PCSrcGE,
    output logic         RegWriteGE,
    output logic         MemWriteGE,
    output logic         MemtoRegGE,
    output logic         BranchTakenE,
    output logic         BusyE,
    output logic [3:0]   FlagsOutE
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    // Counter tracks which MUL cycle we are in; cycle 0 is the IDLE capture cycle.
    localparam int            CW       = $clog2(MUL_LAT);
    localparam logic [CW-1:0] CNT_LAST = CW'(MUL_LAT - 1);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CW-1:0] cnt;

    // NZCV register: [3]=N [2]=Z [1]=C [0]=V
    logic [3:0] nzcv;
    logic [1:0] flag_we;
    logic [3:0] flag_val;

    logic [N-1:0] srca;
    logic [N-1:0] srcb;
    logic [N-1:0] wdata;

    logic cc_ok;
    logic cond_pass;

    logic [N:0]   sum_ext;
    logic [N:0]   dif_ext;
    logic [31:0]  shamt;
    logic [N-1:0] alu_res;
    logic         alu_c;
    logic         alu_v;

    // State captured at MUL issue; D/E is cleared upstream while we are busy.
    logic [N-1:0] cap_a;
    logic [N-1:0] cap_b;
    logic [N-1:0] cap_wd;
    logic [3:0]   cap_a3;
    logic         cap_rw;
    logic         cap_mw;
    logic         cap_m2r;
    logic         cap_pcs;
    logic [1:0]   cap_fw;

    logic         mul_issue;
    logic         mul_done;
    logic [N-1:0] mul_res;

    // Operand forwarding; encoding 11 falls back to the register file value.
    always_comb begin
        case (ForwardAE)
            2'b01:   srca = ResultW;
            2'b10:   srca = ALUResultM;
            default: srca = RD1E;
        endcase
        case (ForwardBE)
            2'b01:   wdata = ResultW;
            2'b10:   wdata = ALUResultM;
            default: wdata = RD2E;
        endcase
        srcb = ALUSrcE ? ExtImmE : wdata;
    end

    // Condition evaluation uses the flags as they stood before this cycle's update.
    always_comb begin
        case (FlagsE)
            4'b0000: cc_ok = nzcv[2];
            4'b0001: cc_ok = ~nzcv[2];
            4'b0010: cc_ok = nzcv[3] ^ nzcv[0];
            4'b0011: cc_ok = ~(nzcv[3] ^ nzcv[0]);
            4'b1110: cc_ok = 1'b1;
            default: cc_ok = 1'b0;
        endcase
        cond_pass = ~CondE | cc_ok;
    end

    // Single-cycle ALU; C is carry-out for ADD and no-borrow for SUB, zero otherwise.
    always_comb begin
        sum_ext = {1'b0, srca} + {1'b0, srcb};
        dif_ext = {1'b0, srca} - {1'b0, srcb};
        shamt   = {27'd0, srcb[4:0]};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (ALUControlE)
            OP_ADD: begin
                alu_res = sum_ext[N-1:0];
                alu_c   = sum_ext[N];
                alu_v   = (srca[N-1] == srcb[N-1]) && (sum_ext[N-1] != srca[N-1]);
            end
            OP_SUB: begin
                alu_res = dif_ext[N-1:0];
                alu_c   = ~dif_ext[N];
                alu_v   = (srca[N-1] != srcb[N-1]) && (dif_ext[N-1] != srca[N-1]);
            end
            OP_AND:  alu_res = srca & srcb;
            OP_OR:   alu_res = srca | srcb;
            OP_XOR:  alu_res = srca ^ srcb;
            OP_SHL:  alu_res = (shamt >= N) ? '0 : (srca << srcb[4:0]);
            OP_SHR:  alu_res = (shamt >= N) ? '0 : (srca >> srcb[4:0]);
            default: alu_res = '0;
        endcase
    end

    // Only the low N bits of the product are architecturally visible.
    assign mul_res   = cap_a * cap_b;
    assign mul_issue = (state == S_IDLE) && (ALUControlE == OP_MUL) && cond_pass;
    assign mul_done  = (state == S_BUSY) && (cnt == CNT_LAST);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: a passing MUL enters BUSY, the last MUL cycle returns to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (mul_issue) state_nxt = S_BUSY;
            S_BUSY:  if (cnt == CNT_LAST) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // MUL cycle counter and operand/control capture at issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            cap_a   <= '0;
            cap_b   <= '0;
            cap_wd  <= '0;
            cap_a3  <= '0;
            cap_rw  <= 1'b0;
            cap_mw  <= 1'b0;
            cap_m2r <= 1'b0;
            cap_pcs <= 1'b0;
            cap_fw  <= 2'b00;
        end else if (state == S_IDLE) begin
            if (mul_issue) begin
                cnt     <= CW'(1);
                cap_a   <= srca;
                cap_b   <= srcb;
                cap_wd  <= wdata;
                cap_a3  <= A3E;
                cap_rw  <= RegWriteE;
                cap_mw  <= MemWriteE;
                cap_m2r <= MemtoRegE;
                cap_pcs <= PCSrcE;
                cap_fw  <= FlagWriteE;
            end else begin
                cnt <= '0;
            end
        end else begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
        end
    end

    // FSM outputs: gated controls, result mux, busy and flag-write selection.
    always_comb begin
        BusyE        = 1'b0;
        PCSrcGE      = 1'b0;
        RegWriteGE   = 1'b0;
        MemWriteGE   = 1'b0;
        MemtoRegGE   = 1'b0;
        BranchTakenE = 1'b0;
        ALUResultE   = '0;
        WriteDataE   = wdata;
        WA3E         = A3E;
        flag_we      = 2'b00;
        flag_val     = 4'b0000;
        if (state == S_BUSY) begin
            WriteDataE = cap_wd;
            WA3E       = cap_a3;
            if (mul_done) begin
                ALUResultE = mul_res;
                PCSrcGE    = cap_pcs;
                RegWriteGE = cap_rw;
                MemWriteGE = cap_mw;
                MemtoRegGE = cap_m2r;
                flag_we    = cap_fw;
                flag_val   = {mul_res[N-1], (mul_res == '0), 2'b00};
            end else begin
                BusyE = 1'b1;
            end
        end else if (ALUControlE == OP_MUL) begin
            // Issue cycle (or a failed-condition MUL) is a bubble.
            BusyE = cond_pass;
        end else if (cond_pass) begin
            ALUResultE   = alu_res;
            PCSrcGE      = PCSrcE;
            RegWriteGE   = RegWriteE;
            MemWriteGE   = MemWriteE;
            MemtoRegGE   = MemtoRegE;
            BranchTakenE = BranchE;
            flag_we      = FlagWriteE;
            flag_val     = {alu_res[N-1], (alu_res == '0), alu_c, alu_v};
        end
        if (rst) begin
            BusyE        = 1'b0;
            PCSrcGE      = 1'b0;
            RegWriteGE   = 1'b0;
            MemWriteGE   = 1'b0;
            MemtoRegGE   = 1'b0;
            BranchTakenE = 1'b0;
            flag_we      = 2'b00;
        end
    end

    // NZCV register; N,Z and C,V fields are written independently.
    always_ff @(posedge clk) begin
        if (rst) begin
            nzcv <= 4'b0000;
        end else begin
            if (flag_we[1]) nzcv[3:2] <= flag_val[3:2];
            if (flag_we[0]) nzcv[1:0] <= flag_val[1:0];
        end
    end

    assign FlagsOutE = nzcv;

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;

    localparam int     N       = 24;
    localparam int     MUL_LAT = 4;
    localparam longint MOD     = longint'(1) << N;

    typedef struct {
        logic         rst;
        logic         pcs, rw, m2r, mw, br, alusrc, cond;
        logic [2:0]   op;
        logic [1:0]   fw, fa, fb;
        logic [3:0]   cc, a3;
        logic [N-1:0] rd1, rd2, imm, alum, resw;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE, CondE;
    logic [2:0]   ALUControlE;
    logic [1:0]   FlagWriteE, ForwardAE, ForwardBE;
    logic [3:0]   FlagsE, A3E;
    logic [N-1:0] RD1E, RD2E, ExtImmE, ALUResultM, ResultW;
    logic [N-1:0] ALUResultE, WriteDataE;
    logic [3:0]   WA3E, FlagsOutE;
    logic         PCSrcGE, RegWriteGE, MemWriteGE, MemtoRegGE, BranchTakenE, BusyE;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    execute_stage #(.N(N), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst(rst),
        .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
        .ALUControlE(ALUControlE), .BranchE(BranchE), .ALUSrcE(ALUSrcE), .FlagWriteE(FlagWriteE),
        .CondE(CondE), .FlagsE(FlagsE), .RD1E(RD1E), .RD2E(RD2E), .ExtImmE(ExtImmE), .A3E(A3E),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ALUResultM(ALUResultM), .ResultW(ResultW),
        .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .WA3E(WA3E),
        .PCSrcGE(PCSrcGE), .RegWriteGE(RegWriteGE), .MemWriteGE(MemWriteGE), .MemtoRegGE(MemtoRegGE),
        .BranchTakenE(BranchTakenE), .BusyE(BusyE), .FlagsOutE(FlagsOutE)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic longint sgn(input longint x);
        return (x >= MOD / 2) ? x - MOD : x;
    endfunction

    function automatic bit cc_ok(input logic [3:0] cc, input logic [3:0] f);
        case (cc)
            4'b0000: return f[2];
            4'b0001: return !f[2];
            4'b0010: return f[3] != f[0];
            4'b0011: return f[3] == f[0];
            4'b1110: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic longint fwd(input logic [1:0] sel, input logic [N-1:0] rd,
                                   input logic [N-1:0] w, input logic [N-1:0] m);
        if (sel == 2'b01) return longint'(w);
        if (sel == 2'b10) return longint'(m);
        return longint'(rd);
    endfunction

    task automatic alu_model(input logic [2:0] op, input longint a, input longint b,
                             output longint res, output bit c, output bit v);
        longint s;
        longint amt;
        c = 1'b0;
        v = 1'b0;
        amt = b % 32;
        case (op)
            3'd0: begin
                s = a + b; res = s % MOD; c = (s >= MOD);
                s = sgn(a) + sgn(b); v = (s >= MOD / 2) || (s < -(MOD / 2));
            end
            3'd1: begin
                res = (a - b + MOD) % MOD; c = (a >= b);
                s = sgn(a) - sgn(b); v = (s >= MOD / 2) || (s < -(MOD / 2));
            end
            3'd2: res = a & b;
            3'd3: res = a | b;
            3'd4: res = a ^ b;
            3'd5: res = (amt >= N) ? 0 : ((a << amt) % MOD);
            3'd6: res = (amt >= N) ? 0 : (a >> amt);
            default: res = (a * b) % MOD;
        endcase
    endtask

    function automatic logic [3:0] upd(input logic [3:0] old, input logic [1:0] fw,
                                       input longint res, input bit c, input bit v);
        logic [3:0] f;
        f = old;
        if (fw[1]) begin f[3] = (res >= MOD / 2); f[2] = (res == 0); end
        if (fw[0]) begin f[1] = c; f[0] = v; end
        return f;
    endfunction

    // model state: current flags and which MUL cycle (1..MUL_LAT) is in Execute, 0 = none
    logic [3:0] m_nzcv = 4'b0000;
    int         m_mul  = 0;
    longint     cap_a, cap_b;
    logic [3:0] cap_a3;
    logic       cap_rw, cap_mw, cap_m2r, cap_pcs;
    logic [1:0] cap_fw;

    longint     e_a, e_b, e_wd, e_res;
    bit         e_c, e_v, e_pass, do_res, do_wd, do_wa;
    logic       e_busy, e_rw, e_mw, e_m2r, e_pcs, e_bt;
    logic [3:0] e_wa, n_nzcv;
    int         n_mul;

    // compare process: every cycle, outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            e_busy = 0; e_rw = 0; e_mw = 0; e_m2r = 0; e_pcs = 0; e_bt = 0;
            do_res = 0; do_wd = 0; do_wa = 0; e_res = 0; e_wd = 0; e_wa = 0;
            n_nzcv = m_nzcv; n_mul = 0;
            if (rst) begin
                n_nzcv = 4'b0000;
            end else if (m_mul >= 2) begin
                do_res = 1;
                if (m_mul < MUL_LAT) begin
                    e_busy = 1;
                    n_mul  = m_mul + 1;
                end else begin
                    e_res = (cap_a * cap_b) % MOD;
                    do_wa = 1; e_wa = cap_a3;
                    e_rw = cap_rw; e_mw = cap_mw; e_m2r = cap_m2r; e_pcs = cap_pcs;
                    n_nzcv = upd(m_nzcv, cap_fw, e_res, 0, 0);
                end
            end else begin
                e_a    = fwd(ForwardAE, RD1E, ResultW, ALUResultM);
                e_wd   = fwd(ForwardBE, RD2E, ResultW, ALUResultM);
                e_b    = ALUSrcE ? longint'(ExtImmE) : e_wd;
                e_pass = !CondE || cc_ok(FlagsE, m_nzcv);
                if (ALUControlE == 3'b111) begin
                    do_res = 1;
                    if (e_pass) begin
                        e_busy = 1; n_mul = 2;
                        cap_a = e_a; cap_b = e_b; cap_a3 = A3E; cap_fw = FlagWriteE;
                        cap_rw = RegWriteE; cap_mw = MemWriteE; cap_m2r = MemtoRegE; cap_pcs = PCSrcE;
                    end
                end else begin
                    do_wd = 1; do_wa = 1; e_wa = A3E;
                    if (e_pass) begin
                        alu_model(ALUControlE, e_a, e_b, e_res, e_c, e_v);
                        do_res = 1;
                        e_rw = RegWriteE; e_mw = MemWriteE; e_m2r = MemtoRegE;
                        e_pcs = PCSrcE; e_bt = BranchE;
                        n_nzcv = upd(m_nzcv, FlagWriteE, e_res, e_c, e_v);
                    end
                end
            end
            chk("BusyE", 32'(BusyE), 32'(e_busy));
            chk("RegWriteGE", 32'(RegWriteGE), 32'(e_rw));
            chk("MemWriteGE", 32'(MemWriteGE), 32'(e_mw));
            chk("MemtoRegGE", 32'(MemtoRegGE), 32'(e_m2r));
            chk("PCSrcGE", 32'(PCSrcGE), 32'(e_pcs));
            chk("BranchTakenE", 32'(BranchTakenE), 32'(e_bt));
            chk("FlagsOutE", 32'(FlagsOutE), 32'(m_nzcv));
            if (do_res) chk("ALUResultE", 32'(ALUResultE), 32'(e_res));
            if (do_wd)  chk("WriteDataE", 32'(WriteDataE), 32'(e_wd));
            if (do_wa)  chk("WA3E", 32'(WA3E), 32'(e_wa));
            m_nzcv = n_nzcv;
            m_mul  = n_mul;
        end
    end

    // ---------------- stimulus ----------------
    function automatic vec_t nop();
        vec_t v;
        v.rst = 0; v.pcs = 0; v.rw = 0; v.m2r = 0; v.mw = 0; v.br = 0; v.alusrc = 0; v.cond = 0;
        v.op = 3'b000; v.fw = 2'b00; v.fa = 2'b00; v.fb = 2'b00; v.cc = 4'b1110; v.a3 = 4'd0;
        v.rd1 = '0; v.rd2 = '0; v.imm = '0; v.alum = '0; v.resw = '0;
        return v;
    endfunction

    function automatic vec_t opv(input logic [2:0] op, input logic [N-1:0] rd1, input logic [N-1:0] rd2,
                                 input logic [N-1:0] imm, input logic alusrc, input logic [1:0] fw);
        vec_t v;
        v = nop();
        v.op = op; v.rd1 = rd1; v.rd2 = rd2; v.imm = imm; v.alusrc = alusrc; v.fw = fw;
        v.rw = 1; v.m2r = 1; v.a3 = 4'd1;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        @(posedge clk);
        #1;
        rst = v.rst; PCSrcE = v.pcs; RegWriteE = v.rw; MemtoRegE = v.m2r; MemWriteE = v.mw;
        ALUControlE = v.op; BranchE = v.br; ALUSrcE = v.alusrc; FlagWriteE = v.fw; CondE = v.cond;
        FlagsE = v.cc; RD1E = v.rd1; RD2E = v.rd2; ExtImmE = v.imm; A3E = v.a3;
        ForwardAE = v.fa; ForwardBE = v.fb; ALUResultM = v.alum; ResultW = v.resw;
        @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog expired at %0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        vec_t v;
        vec_t junk;
        rst = 1; PCSrcE = 0; RegWriteE = 0; MemtoRegE = 0; MemWriteE = 0; ALUControlE = 3'b000;
        BranchE = 0; ALUSrcE = 0; FlagWriteE = 2'b00; CondE = 0; FlagsE = 4'b1110;
        RD1E = '0; RD2E = '0; ExtImmE = '0; A3E = '0; ForwardAE = 2'b00; ForwardBE = 2'b00;
        ALUResultM = '0; ResultW = '0;
        chk_en = 1'b1;

        // reset with active controls and a MUL request on the inputs
        v = nop(); v.rst = 1; v.rw = 1; v.mw = 1; v.pcs = 1; v.br = 1; v.op = 3'b111;
        drive(v);
        chk("rst_busy", 32'(BusyE), 0);
        chk("rst_regwrite", 32'(RegWriteGE), 0);
        chk("rst_branch", 32'(BranchTakenE), 0);
        chk("rst_flags", 32'(FlagsOutE), 0);

        // ADD overflow into the sign bit
        drive(opv(3'b000, 24'h7FFFFF, 24'h0, 24'h1, 1, 2'b11));
        chk("add_ovf_res", 32'(ALUResultE), 32'h800000);
        chk("add_regwrite", 32'(RegWriteGE), 1);
        drive(nop());
        chk("add_ovf_flags", 32'(FlagsOutE), 32'b1001);

        // SUB to zero, then EQ passes and NE fails
        drive(opv(3'b001, 24'd5, 24'd5, 24'd0, 0, 2'b11));
        chk("sub_zero_res", 32'(ALUResultE), 0);
        v = opv(3'b000, 24'd1, 24'd2, 24'd0, 0, 2'b00); v.cond = 1; v.cc = 4'b0000;
        drive(v);
        chk("eq_flags", 32'(FlagsOutE), 32'b0110);
        chk("eq_regwrite", 32'(RegWriteGE), 1);
        chk("eq_res", 32'(ALUResultE), 3);
        v = opv(3'b000, 24'd1, 24'd1, 24'd0, 0, 2'b11); v.cond = 1; v.cc = 4'b0001;
        drive(v);
        chk("ne_regwrite", 32'(RegWriteGE), 0);
        drive(nop());
        chk("ne_flags_kept", 32'(FlagsOutE), 32'b0110);

        // forwarding paths
        v = opv(3'b000, 24'hAAAAAA, 24'h555555, 24'd0, 0, 2'b00);
        v.fa = 2'b10; v.alum = 24'h10; v.fb = 2'b01; v.resw = 24'h3;
        drive(v);
        chk("fwd_res", 32'(ALUResultE), 32'h13);
        chk("fwd_wdata", 32'(WriteDataE), 3);
        v = opv(3'b000, 24'h100, 24'h2, 24'd0, 0, 2'b00);
        v.fa = 2'b11; v.fb = 2'b11; v.alum = 24'h999; v.resw = 24'h777;
        drive(v);
        chk("fwd11_res", 32'(ALUResultE), 32'h102);

        // MUL 0x1000*0x1000 with forwarded A and junk on the inputs while busy
        v = opv(3'b111, 24'h1, 24'h0, 24'h1000, 1, 2'b11); v.fa = 2'b10; v.alum = 24'h1000; v.a3 = 4'd5;
        drive(v);
        chk("mul1_busy", 32'(BusyE), 1);
        chk("mul1_rw", 32'(RegWriteGE), 0);
        junk = opv(3'b000, 24'h7, 24'h7, 24'h7, 0, 2'b11); junk.alum = 24'h7; junk.mw = 1; junk.a3 = 4'hF;
        for (int i = 2; i <= MUL_LAT; i++) begin
            drive(junk);
            if (i < MUL_LAT) begin
                chk("mul1_busy_mid", 32'(BusyE), 1);
                chk("mul1_rw_mid", 32'(RegWriteGE), 0);
            end else begin
                chk("mul1_busy_last", 32'(BusyE), 0);
                chk("mul1_rw_last", 32'(RegWriteGE), 1);
                chk("mul1_res", 32'(ALUResultE), 0);
                chk("mul1_wa3", 32'(WA3E), 5);
            end
        end

        // back-to-back MUL
        v = opv(3'b111, 24'h123, 24'h456, 24'd0, 0, 2'b00); v.a3 = 4'd9;
        drive(v);
        chk("mul2_busy", 32'(BusyE), 1);
        chk("mul1_flags", 32'(FlagsOutE), 32'b0100);
        for (int i = 2; i <= MUL_LAT; i++) drive(nop());
        chk("mul2_res", 32'(ALUResultE), 32'h04EDC2);
        chk("mul2_wa3", 32'(WA3E), 9);

        // MUL with failed condition is a single bubble
        v = opv(3'b111, 24'd3, 24'd4, 24'd0, 0, 2'b11); v.cond = 1; v.cc = 4'b0101;
        drive(v);
        chk("mulnc_busy", 32'(BusyE), 0);
        chk("mulnc_rw", 32'(RegWriteGE), 0);
        drive(opv(3'b000, 24'hFFFFF0, 24'd4, 24'd0, 0, 2'b11));
        chk("mulnc_next_res", 32'(ALUResultE), 32'hFFFFF4);
        chk("mulnc_flags", 32'(FlagsOutE), 32'b0100);

        // reset in MUL cycle 2 aborts it
        drive(opv(3'b111, 24'd2, 24'd3, 24'd0, 0, 2'b11));
        chk("abort_busy0", 32'(BusyE), 1);
        v = nop(); v.rst = 1;
        drive(v);
        chk("abort_busy_rst", 32'(BusyE), 0);
        for (int i = 0; i < MUL_LAT; i++) begin
            drive(nop());
            chk("abort_busy", 32'(BusyE), 0);
            chk("abort_rw", 32'(RegWriteGE), 0);
            chk("abort_flags", 32'(FlagsOutE), 0);
        end

        // branch conditions on N=1, V=0
        drive(opv(3'b001, 24'd1, 24'd2, 24'd0, 0, 2'b11));
        chk("sub_neg_res", 32'(ALUResultE), 32'hFFFFFF);
        v = nop(); v.cond = 1; v.cc = 4'b0010; v.br = 1; v.pcs = 1;
        drive(v);
        chk("lt_taken", 32'(BranchTakenE), 1);
        chk("lt_pcsrc", 32'(PCSrcGE), 1);
        chk("lt_flags", 32'(FlagsOutE), 32'b1000);
        v.cc = 4'b1111;
        drive(v);
        chk("never_taken", 32'(BranchTakenE), 0);
        chk("never_pcsrc", 32'(PCSrcGE), 0);
        v.cc = 4'b0011;
        drive(v);
        chk("ge_taken", 32'(BranchTakenE), 0);
        v.cc = 4'b1110;
        drive(v);
        chk("al_taken", 32'(BranchTakenE), 1);

        // shifts, logic ops, arithmetic boundaries
        drive(opv(3'b101, 24'd1, 24'd0, 24'd23, 1, 2'b11));
        chk("shl23", 32'(ALUResultE), 32'h800000);
        drive(opv(3'b101, 24'd1, 24'd0, 24'd24, 1, 2'b11));
        chk("shl24", 32'(ALUResultE), 0);
        drive(opv(3'b101, 24'd1, 24'd0, 24'h21, 1, 2'b11));
        chk("shl_amt_low5", 32'(ALUResultE), 2);
        drive(opv(3'b110, 24'h800000, 24'd23, 24'd0, 0, 2'b11));
        chk("shr23", 32'(ALUResultE), 1);
        drive(opv(3'b110, 24'h800000, 24'd31, 24'd0, 0, 2'b11));
        chk("shr31", 32'(ALUResultE), 0);
        drive(opv(3'b010, 24'hF0F0F0, 24'h0FF0FF, 24'd0, 0, 2'b10));
        chk("and", 32'(ALUResultE), 32'h00F0F0);
        drive(opv(3'b011, 24'hF0F0F0, 24'h0FF0FF, 24'd0, 0, 2'b10));
        chk("or", 32'(ALUResultE), 32'hFFF0FF);
        drive(opv(3'b100, 24'hF0F0F0, 24'h0FF0FF, 24'd0, 0, 2'b10));
        chk("xor", 32'(ALUResultE), 32'hFF000F);
        drive(opv(3'b001, 24'h800000, 24'd1, 24'd0, 0, 2'b11));
        chk("sub_ovf_res", 32'(ALUResultE), 32'h7FFFFF);
        drive(nop());
        chk("sub_ovf_flags", 32'(FlagsOutE), 32'b0011);
        drive(opv(3'b000, 24'hFFFFFF, 24'd0, 24'd1, 1, 2'b11));
        chk("add_carry_res", 32'(ALUResultE), 0);
        drive(nop());
        chk("add_carry_flags", 32'(FlagsOutE), 32'b0110);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
